// File: rtl/core_done_if.sv
// Handshake bundle for core_done_collector.
// CORE_DONE_TIMEOUT_EN adds the timeout pulse.
interface core_done_if;
  logic [4:0]  num_core;
  logic        start;
  logic [15:0] done;
  logic        busy;
  logic        all_done;
  logic [4:0]  done_count;
  logic [15:0] core_mask;
`ifdef CORE_DONE_TIMEOUT_EN
  logic        timeout;
`endif

  modport master (
    output num_core, start, done,
    input  busy, all_done, done_count, core_mask
`ifdef CORE_DONE_TIMEOUT_EN
    , input timeout
`endif
  );

  modport slave (
    input  num_core, start, done,
    output busy, all_done, done_count, core_mask
`ifdef CORE_DONE_TIMEOUT_EN
    , output timeout
`endif
  );
endinterface

// File: rtl/core_done_collector.sv
// Collects per-core done flags for a run and pulses all_done.
// Optional WAIT timeout abort under CORE_DONE_TIMEOUT_EN.
module core_done_collector #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input logic       clk,
  input logic       rst,
  core_done_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t      state;
  logic [15:0] flags;
  logic [15:0] mask_q;
  logic [4:0]  count_q;
  logic        busy_q;
  logic        all_done_q;
  logic [15:0] next_flags;
  logic        complete;

  assign next_flags = flags | (bus.done & mask_q);
  assign complete   = (next_flags == mask_q);

  // 4 cores use cores 1,2,5,6; unsupported counts fall back to that.
  function automatic logic [15:0] map_mask(input logic [4:0] n);
    logic [15:0] m;
    m = 16'h0033;
    unique case (1'b1)
      (n == 5'd1):  m = 16'h0001;
      (n == 5'd2):  m = 16'h0003;
      (n == 5'd8):  m = 16'h00FF;
      (n == 5'd16): m = 16'hFFFF;
      default:      m = 16'h0033;
    endcase
    return m;
  endfunction

  function automatic logic [4:0] popcnt(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++)
      c = c + {4'd0, v[i]};
    return c;
  endfunction

`ifdef CORE_DONE_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        timeout_q;
  logic        expired;

  assign expired     = (wait_cnt == TIMEOUT_CYCLES - 16'd1);
  assign bus.timeout = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      flags      <= '0;
      mask_q     <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      all_done_q <= 1'b0;
`ifdef CORE_DONE_TIMEOUT_EN
      wait_cnt   <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      all_done_q <= 1'b0;
`ifdef CORE_DONE_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.start) begin
            mask_q  <= map_mask(bus.num_core);
            flags   <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state   <= WAIT;
`ifdef CORE_DONE_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        WAIT: begin
          flags   <= next_flags;
          count_q <= popcnt(next_flags);
          if (complete) begin
            busy_q     <= 1'b0;
            all_done_q <= 1'b1;
            state      <= DONE;
`ifdef CORE_DONE_TIMEOUT_EN
          end else if (expired) begin
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
`endif
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.all_done   = all_done_q;
  assign bus.done_count = count_q;
  assign bus.core_mask  = mask_q;
endmodule

// File: tb/tb_core_done_collector.sv
// Randomized bench for core_done_collector with a run-level model.
// Build with CORE_DONE_TIMEOUT_EN to also cover the timeout abort.
module tb_core_done_collector;
`ifdef CORE_DONE_TIMEOUT_EN
  localparam bit          TO_ON = 1'b1;
  localparam logic [15:0] TO    = 16'd8;
`else
  localparam bit          TO_ON = 1'b0;
  localparam logic [15:0] TO    = 16'd1000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  core_done_if bus ();

  core_done_collector #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Run-level reference: which cores have reported, and run phase.
  bit          m_busy;
  bit          m_pulse;
  bit          m_to;
  logic [15:0] m_seen;
  logic [15:0] m_mask;
  logic [4:0]  m_count;
  int          m_wait;

  function automatic logic [15:0] exp_mask(input logic [4:0] n);
    case (n)
      5'd1:    return 16'h0001;
      5'd2:    return 16'h0003;
      5'd8:    return 16'h00FF;
      5'd16:   return 16'hFFFF;
      default: return 16'h0033;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_pulse = 0; m_to = 0;
    m_seen = '0; m_mask = '0; m_count = '0; m_wait = 0;
  endtask

  task automatic step(input bit s, input logic [4:0] n,
                      input logic [15:0] d);
    bus.start = s; bus.num_core = n; bus.done = d;
    @(posedge clk);
    m_to = 0;
    if (m_pulse) begin
      m_pulse = 0;
    end else if (m_busy) begin
      m_seen  = m_seen | (d & m_mask);
      m_count = 5'($countones(m_seen));
      if (m_seen == m_mask) begin
        m_busy = 0; m_pulse = 1;
      end else if (TO_ON && m_wait == int'(TO) - 1) begin
        m_busy = 0; m_to = 1;
      end else begin
        m_wait++;
      end
    end else if (s) begin
      m_mask = exp_mask(n); m_seen = '0; m_count = '0;
      m_busy = 1; m_wait = 0;
    end
    @(negedge clk);
    bus.start = 1'b0; bus.done = '0;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.num_core = 5'd1; bus.done = 16'hFFFF;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.all_done !== 1'b0 ||
        bus.done_count !== 5'd0 || bus.core_mask !== 16'h0000) begin
      failures++;
      $display("FAIL reset busy=%b all_done=%b cnt=%0d mask=%h want 0",
               bus.busy, bus.all_done, bus.done_count, bus.core_mask);
    end
    rst = 1'b0;
    bus.done = '0;
  endtask

  task automatic test_single();
    step(1, 5'd1, 16'h0000);
    step(0, 5'd1, 16'h0001);
    checks++;
    if (bus.all_done !== 1'b1 || bus.done_count !== 5'd1 ||
        bus.core_mask !== 16'h0001 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL single all_done=%b cnt=%0d mask=%h busy=%b want 1/1/0001/0",
               bus.all_done, bus.done_count, bus.core_mask, bus.busy);
    end
    step(1, 5'd8, 16'h0000);
    checks++;
    if (bus.all_done !== 1'b0 || bus.busy !== 1'b0 ||
        bus.core_mask !== 16'h0001 || bus.done_count !== 5'd1) begin
      failures++;
      $display("FAIL done_hold all_done=%b busy=%b mask=%h cnt=%0d",
               bus.all_done, bus.busy, bus.core_mask, bus.done_count);
    end
  endtask

  task automatic test_mask4();
    logic [15:0] pulses [4];
    pulses = '{16'h0001, 16'h0002, 16'h0010, 16'h0020};
    step(0, 5'd4, 16'h0020);
    step(1, 5'd4, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      step(0, 5'd4, 16'hFFCC);
      step(0, 5'd4, 16'hFFCC | pulses[i]);
      checks++;
      if (bus.all_done !== (i == 3) || bus.done_count !== 5'(i + 1) ||
          bus.core_mask !== 16'h0033) begin
        failures++;
        $display("FAIL mask4 i=%0d all_done=%b cnt=%0d mask=%h",
                 i, bus.all_done, bus.done_count, bus.core_mask);
      end
    end
    step(0, 5'd4, 16'h0000);
  endtask

  task automatic test_odd_num();
    step(1, 5'd3, 16'h0000);
    checks++;
    if (bus.core_mask !== 16'h0033 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL odd_num mask=%h busy=%b want 0033/1",
               bus.core_mask, bus.busy);
    end
    step(1, 5'd16, 16'h0000);
    checks++;
    if (bus.core_mask !== 16'h0033 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_ignored mask=%h busy=%b want 0033/1",
               bus.core_mask, bus.busy);
    end
    step(0, 5'd16, 16'h0033);
    step(0, 5'd16, 16'h0000);
  endtask

  task automatic test_stagger16();
    int order [16];
    int pulses;
    pulses = 0;
    for (int i = 0; i < 16; i++) order[i] = i;
    for (int i = 15; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    step(1, 5'd16, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      step(0, 5'd16, 16'(1) << order[i]);
      if (bus.all_done === 1'b1) pulses++;
      checks++;
      if (bus.done_count !== m_count || bus.busy !== m_busy) begin
        failures++;
        $display("FAIL stagger16 i=%0d cnt=%0d/%0d busy=%b/%b",
                 i, bus.done_count, m_count, bus.busy, m_busy);
      end
    end
    repeat (3) begin
      step(0, 5'd16, 16'hFFFF);
      if (bus.all_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1 || bus.done_count !== 5'd16) begin
      failures++;
      $display("FAIL stagger16_pulses pulses=%0d cnt=%0d want 1/16",
               pulses, bus.done_count);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 5'd8, 16'h0000);
    step(0, 5'd8, 16'h000F);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.all_done !== 1'b0 ||
        bus.done_count !== 5'd0 || bus.core_mask !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mid busy=%b all_done=%b cnt=%0d mask=%h want 0",
               bus.busy, bus.all_done, bus.done_count, bus.core_mask);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, 5'd8, 16'hFFFF);
      checks++;
      if (bus.all_done !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_after i=%0d all_done=%b busy=%b",
                 i, bus.all_done, bus.busy);
      end
    end
  endtask

  task automatic test_timeout();
`ifdef CORE_DONE_TIMEOUT_EN
    bit seen_all;
    seen_all = 0;
    step(1, 5'd2, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      step(0, 5'd2, 16'h0001);
      if (bus.all_done === 1'b1) seen_all = 1;
      checks++;
      if (bus.timeout !== (i == 7) || bus.busy !== (i != 7)) begin
        failures++;
        $display("FAIL timeout i=%0d timeout=%b busy=%b",
                 i, bus.timeout, bus.busy);
      end
    end
    step(0, 5'd2, 16'h0000);
    checks++;
    if (seen_all || bus.timeout !== 1'b0 || bus.all_done !== 1'b0) begin
      failures++;
      $display("FAIL timeout_end all_seen=%b timeout=%b all_done=%b",
               seen_all, bus.timeout, bus.all_done);
    end
`endif
  endtask

  task automatic test_random();
    logic [4:0] nums [6];
    nums = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd0};
    for (int c = 0; c < 600; c++) begin
      logic [4:0]  n;
      logic [15:0] d;
      bit          s;
      n = nums[$urandom_range(5, 0)];
      if (n == 5'd0) n = 5'($urandom);
      d = 16'($urandom & $urandom & $urandom);
      s = ($urandom_range(3, 0) == 0);
      step(s, n, d);
      checks++;
      if (bus.busy !== m_busy || bus.all_done !== m_pulse ||
          bus.done_count !== m_count || bus.core_mask !== m_mask) begin
        failures++;
        $display("FAIL rand c=%0d busy=%b/%b all_done=%b/%b cnt=%0d/%0d mask=%h/%h",
                 c, bus.busy, m_busy, bus.all_done, m_pulse,
                 bus.done_count, m_count, bus.core_mask, m_mask);
      end
`ifdef CORE_DONE_TIMEOUT_EN
      checks++;
      if (bus.timeout !== m_to) begin
        failures++;
        $display("FAIL rand_timeout c=%0d got=%b want=%b",
                 c, bus.timeout, m_to);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mask4();
    test_odd_num();
    test_stagger16();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/core_done_collector.md
CORE_DONE_COLLECTOR -- requirements
Module: core_done_collector

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd1000, the WAIT-state cycle limit; used only when CORE_DONE_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock for the block; all state updates occur on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 num_core  input  5  number of active cores (1, 2, 4, 8 or 16); sampled only on an accepted start.
REQ-005 start  input  1  one-cycle request to begin collecting completions for a new run.
REQ-006 done  input  16  per-core completion flags; done[0] is core 1 and done[15] is core 16; level or pulse accepted.
REQ-007 busy  output  1  high while in the WAIT state.
REQ-008 all_done  output  1  one-cycle pulse when every enabled core has reported done.
REQ-009 done_count  output  5  number of enabled cores that have reported done in the current run.
REQ-010 core_mask  output  16  registered enable mask latched at start.
REQ-011 timeout  output  1  one-cycle pulse on timeout abort; exists only when CORE_DONE_TIMEOUT_EN is defined.

Function
REQ-012 The block SHALL map num_core to a mask as follows: 1 -> 16'h0001; 2 -> 16'h0003; 4 -> 16'h0033 (cores 1, 2, 5, 6); 8 -> 16'h00FF; 16 -> 16'hFFFF; any other value -> 16'h0033.
REQ-013 The block SHALL implement the states IDLE, WAIT and DONE, with IDLE as the reset state.
REQ-014 IDLE: if start=1, the block SHALL latch the mask into core_mask, clear the sticky flags and done_count, and go to WAIT on the next edge; otherwise it SHALL stay in IDLE.
REQ-015 WAIT: on each edge, the block SHALL update sticky flags as flags <= flags | (done & core_mask).
REQ-016 Bits of done outside core_mask SHALL be ignored at all times.
REQ-017 done_count SHALL equal the popcount of the sticky flags, registered and updated on the same edge as the flags.
REQ-018 WAIT -> DONE: when (flags | (done & core_mask)) == core_mask, the block SHALL move to DONE on that same edge.
REQ-019 all_done SHALL be high for exactly the single cycle spent in DONE, i.e. the cycle after the edge on which the final done bit was sampled.
REQ-020 DONE SHALL always go to IDLE on the next edge; start asserted while in DONE SHALL be ignored.
REQ-021 start asserted in WAIT SHALL be ignored; the run in progress is neither restarted nor re-masked.
REQ-022 All enabled cores reporting done in the first WAIT cycle SHALL give all_done two cycles after start.
REQ-023 A done bit asserted in IDLE SHALL NOT be recorded.
REQ-024 core_mask and done_count SHALL hold their values through DONE and IDLE until the next accepted start.
REQ-025 busy SHALL equal (state == WAIT).

Reset
REQ-026 While rst=1, regardless of clk: state=IDLE, busy=0, all_done=0, done_count=0, core_mask=16'h0000, sticky flags=0, timeout=0, timeout counter=0.
REQ-027 Reset asserted mid-run SHALL abort the run with no all_done pulse.
REQ-028 After rst deasserts, the block SHALL accept start on the first rising edge.

Configuration
REQ-029 Macro CORE_DONE_TIMEOUT_EN defined: a 16-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-030 With the macro defined, when the counter equals TIMEOUT_CYCLES-1 and the completion condition is false, the block SHALL go to IDLE, pulse timeout for 1 cycle and give no all_done pulse.
REQ-031 With the macro defined, completion and timeout in the same cycle SHALL resolve as completion.
REQ-032 Macro not defined: no timeout port and no counter; WAIT SHALL persist until completion or reset.

Verification
REQ-033 num_core=1, start, then done=16'h0001 in the first WAIT cycle -> all_done high in cycle start+2, done_count=1, core_mask=16'h0001.
REQ-034 num_core=4, done bits 1, 2 and 5 pulsed in separate cycles, done=16'hFFCC held throughout -> all_done only after core 6 reports, done_count=4, core_mask=16'h0033.
REQ-035 num_core=5'd3 -> core_mask=16'h0033; num_core=16 with all 16 bits staggered -> exactly one all_done pulse, done_count=16.
REQ-036 Second start in WAIT with num_core changed -> core_mask unchanged; rst mid-WAIT -> all outputs 0 immediately, no all_done.
REQ-037 CORE_DONE_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, num_core=2, only core 1 done -> timeout pulse after 8 WAIT cycles, busy=0, all_done never asserted.
